// File: rtl/uart_bus_sched.sv
// Bus master for one UART: programs the divider, polls status, drains RX into a
// one-entry stream buffer and round-robins NUM_REQ TX byte streams onto the UART.
// Optional packet lock (grant held until req_last): define UART_BUS_SCHED_PKT_LOCK_EN.
module uart_bus_sched #(
    parameter int          NUM_REQ      = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [15:0] CLK_DIV_INIT = 16'd103
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rx_valid,
    output logic [7:0]             rx_data,
    input  logic                   rx_ready,
    output logic [31:0]            address_out,
    output logic                   sel_out,
    output logic                   read_out,
    output logic [3:0]             write_mask_out,
    output logic [31:0]            write_value_out,
    input  logic [31:0]            read_value_in,
    input  logic                   ready_in,
    output logic                   busy
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {INIT, POLL, RD, WR} state_t;

    state_t          state, state_nx;
    logic            en;
    logic [PW-1:0]   rr_ptr, grant, cand, grant_inc;
    logic            cand_ok;
    logic [7:0]      wr_byte;
    logic            rx_full;
    logic [7:0]      rx_byte;
    logic            done;
    logic            locked_q;

    function automatic int wrap_idx(input int p, input int k);
        int s;
        s = p + k;
        return (s >= NUM_REQ) ? s - NUM_REQ : s;
    endfunction

    // en is cleared asynchronously so every bus output drops the moment reset asserts
    assign done      = en & ready_in;
    assign grant_inc = (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    assign rx_valid  = rx_full;
    assign rx_data   = rx_byte;
    assign busy      = en & ((state != POLL) | locked_q);

`ifdef UART_BUS_SCHED_PKT_LOCK_EN
    logic            locked;
    logic [PW-1:0]   lock_id;
    logic            unused_rd;
    assign locked_q  = locked;
    assign unused_rd = ^read_value_in[31:8];
`else
    logic            unused_rd;
    assign locked_q  = 1'b0;
    assign unused_rd = ^{read_value_in[31:8], req_last};
`endif

    // Descending scan so the nearest valid requester at or after rr_ptr wins
    always_comb begin
        cand    = '0;
        cand_ok = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[PW'(wrap_idx(int'(rr_ptr), k))]) begin
                cand    = PW'(wrap_idx(int'(rr_ptr), k));
                cand_ok = 1'b1;
            end
        end
`ifdef UART_BUS_SCHED_PKT_LOCK_EN
        if (locked) begin
            cand    = lock_id;
            cand_ok = req_valid[lock_id];
        end
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            INIT: if (done) state_nx = POLL;
            POLL: if (done) begin
                if (read_value_in[1] && !rx_full)     state_nx = RD;
                else if (read_value_in[0] && cand_ok) state_nx = WR;
                else                                  state_nx = POLL;
            end
            RD:   if (done) state_nx = POLL;
            WR:   if (done) state_nx = POLL;
            default: state_nx = INIT;
        endcase
    end

    always_comb begin
        sel_out         = 1'b0;
        read_out        = 1'b0;
        address_out     = '0;
        write_mask_out  = '0;
        write_value_out = '0;
        req_ready       = '0;
        if (en) begin
            sel_out = 1'b1;
            case (state)
                INIT: begin
                    address_out     = BASE_ADDR;
                    write_mask_out  = 4'b0011;
                    write_value_out = {16'b0, CLK_DIV_INIT};
                end
                POLL: begin
                    address_out = BASE_ADDR + 32'h4;
                    read_out    = 1'b1;
                end
                RD: begin
                    address_out = BASE_ADDR + 32'h8;
                    read_out    = 1'b1;
                end
                WR: begin
                    address_out      = BASE_ADDR + 32'h8;
                    write_mask_out   = 4'b0001;
                    write_value_out  = {24'b0, wr_byte};
                    req_ready[grant] = ready_in;
                end
                default: sel_out = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en    <= 1'b0;
            state <= INIT;
        end else begin
            en    <= 1'b1;
            if (en) state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant   <= '0;
            wr_byte <= '0;
            rr_ptr  <= '0;
`ifdef UART_BUS_SCHED_PKT_LOCK_EN
            locked  <= 1'b0;
            lock_id <= '0;
`endif
        end else begin
            // Grant and byte are frozen on entry so a stalled write stays stable
            if (en && state == POLL && state_nx == WR) begin
                grant   <= cand;
                wr_byte <= req_data[{cand, 3'b000} +: 8];
            end
            if (en && state == WR && done) begin
`ifdef UART_BUS_SCHED_PKT_LOCK_EN
                if (!req_last[grant]) begin
                    locked  <= 1'b1;
                    lock_id <= grant;
                end else begin
                    locked  <= 1'b0;
                    rr_ptr  <= grant_inc;
                end
`else
                rr_ptr <= grant_inc;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_full <= 1'b0;
            rx_byte <= '0;
        end else if (en && state == RD && done) begin
            rx_full <= 1'b1;
            rx_byte <= read_value_in[7:0];
        end else if (rx_full && rx_ready) begin
            rx_full <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_bus_sched.sv
// Scoreboard bench for uart_bus_sched: a UART bus model, per-requester byte
// queues, and expected bus accesses / RX bytes popped as the DUT produces them.
module tb_uart_bus_sched;
    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid, req_last, req_ready;
    logic [8*N-1:0]    req_data;
    logic              rx_valid, rx_ready;
    logic [7:0]        rx_data;
    logic [31:0]       address_out, write_value_out, read_value_in;
    logic              sel_out, read_out, ready_in, busy;
    logic [3:0]        write_mask_out;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wd;
        logic [N-1:0] rdy;
    } acc_t;

    acc_t        exp_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  rb [N][16];
    logic        rl [N][16];
    int          rcnt [N];
    int          ridx [N];
    logic [7:0]  status, rx_src;
    logic        stall_mode;
    int          wr_age;
    int          n_chk = 0, n_fail = 0;

    uart_bus_sched #(.NUM_REQ(N), .BASE_ADDR(32'h0), .CLK_DIV_INIT(16'd103)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .address_out(address_out), .sel_out(sel_out), .read_out(read_out),
        .write_mask_out(write_mask_out), .write_value_out(write_value_out),
        .read_value_in(read_value_in), .ready_in(ready_in), .busy(busy)
    );

    always #5 clk = ~clk;

    assign read_value_in = (address_out == 32'h4) ? {24'b0, status} :
                           (address_out == 32'h8) ? {24'b0, rx_src} : 32'h0;
    assign ready_in = !(stall_mode && sel_out && address_out == 32'h8 &&
                        write_mask_out == 4'b0001 && wr_age < 3);

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (ridx[i] < rcnt[i]) begin
                req_valid[i]        = 1'b1;
                req_last[i]         = rl[i][ridx[i]];
                req_data[8*i +: 8]  = rb[i][ridx[i]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_acc(input logic rd, input logic [31:0] addr, input logic [3:0] mask,
                            input logic [31:0] wd, input logic [N-1:0] rdy);
        acc_t a;
        a.rd = rd; a.addr = addr; a.mask = mask; a.wd = wd; a.rdy = rdy;
        exp_q.push_back(a);
    endtask

    task automatic push_wr(input int i, input logic [7:0] b);
        push_acc(1'b0, 32'h8, 4'b0001, {24'b0, b}, N'(1) << i);
    endtask

    task automatic add_byte(input int i, input logic [7:0] b, input logic last);
        rb[i][rcnt[i]] = b;
        rl[i][rcnt[i]] = last;
        rcnt[i]++;
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget && (exp_q.size() != 0 || rx_q.size() != 0); c++)
            @(posedge clk);
        #1;
        chk("drain", exp_q.size() + rx_q.size(), 0);
    endtask

    task automatic rx_pulse();
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    // Bus/requester monitor: compares each completed access, tracks stalls
    initial begin
        logic [N-1:0] cons;
        logic         stall_seen, need_poll, is_dwr;
        int           acc_cyc;
        logic [31:0]  h_addr, h_wd;
        logic [4:0]   h_ctl;
        acc_t         e;
        acc_cyc = 0; need_poll = 1'b0; wr_age = 0;
        for (int i = 0; i < N; i++) ridx[i] = 0;
        forever begin
            @(negedge clk);
            cons = req_ready;
            stall_seen = 1'b0;
            if (sel_out) begin
                is_dwr = (address_out == 32'h8) && !read_out && write_mask_out == 4'b0001;
                if (acc_cyc == 0) begin
                    h_addr = address_out; h_wd = write_value_out; h_ctl = {read_out, write_mask_out};
                end else begin
                    chk("hold_addr", address_out, h_addr);
                    chk("hold_wd", write_value_out, h_wd);
                    chk("hold_ctl", {27'b0, read_out, write_mask_out}, {27'b0, h_ctl});
                end
                if (!ready_in) begin
                    if (is_dwr) begin
                        chk("rdy_early", {28'b0, req_ready}, 0);
                        chk("busy_wr", {31'b0, busy}, 1);
                        stall_seen = 1'b1;
                    end
                    acc_cyc++;
                end else begin
                    if (address_out == 32'h4 && read_out) begin
                        need_poll = 1'b0;
                    end else begin
                        chk("follow_poll", {31'b0, need_poll}, 0);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_acc", address_out, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            chk("acc_addr", address_out, e.addr);
                            chk("acc_rd", {31'b0, read_out}, {31'b0, e.rd});
                            chk("acc_mask", {28'b0, write_mask_out}, {28'b0, e.mask});
                            chk("acc_wd", write_value_out, e.wd);
                            chk("acc_rdy", {28'b0, req_ready}, {28'b0, e.rdy});
                            if (stall_mode && is_dwr) chk("wr_cycles", acc_cyc + 1, 4);
                        end
                        need_poll = 1'b1;
                    end
                    acc_cyc = 0;
                end
            end else begin
                acc_cyc = 0;
            end
            if (rx_valid && rx_ready) begin
                if (rx_q.size() == 0) chk("unexpected_rx", {24'b0, rx_data}, 32'hFFFF_FFFF);
                else                  chk("rx_data", {24'b0, rx_data}, {24'b0, rx_q.pop_front()});
            end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) if (cons[i]) ridx[i]++;
            wr_age = stall_seen ? wr_age + 1 : 0;
        end
    end

    initial begin
        reset = 1'b0; status = 8'h0; rx_src = 8'h0; rx_ready = 1'b0; stall_mode = 1'b0;
        for (int i = 0; i < N; i++) rcnt[i] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", {31'b0, sel_out}, 0);
        chk("rst_addr", address_out, 0);
        chk("rst_wd", write_value_out, 0);
        chk("rst_ctl", {27'b0, read_out, write_mask_out}, 0);
        chk("rst_rdy", {28'b0, req_ready}, 0);
        chk("rst_rx", {23'b0, rx_valid, rx_data}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        push_acc(1'b0, 32'h0, 4'b0011, 32'h0000_0067, '0);
        reset = 1'b1;
        wait_done(50);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", {31'b0, busy}, 0);

        // Round-robin TX: req1 then req3
        add_byte(1, 8'h41, 1'b1);
        add_byte(3, 8'h42, 1'b1);
        push_wr(1, 8'h41);
        push_wr(3, 8'h42);
        status = 8'h1;
        wait_done(100);
        status = 8'h0;

        // RX before TX when both ready
        rx_src = 8'h5A;
        add_byte(0, 8'h77, 1'b1);
        push_acc(1'b1, 32'h8, 4'b0000, 32'h0, '0);
        push_wr(0, 8'h77);
        status = 8'h3;
        wait_done(100);
        chk("rx_valid_held", {31'b0, rx_valid}, 1);
        chk("rx_byte", {24'b0, rx_data}, 32'h5A);

        // Holding register full: no reads of DATA until drained
        status = 8'h2;
        repeat (20) @(posedge clk);
        #1;
        chk("rx_still_full", {31'b0, rx_valid}, 1);
        rx_src = 8'h3C;
        rx_q.push_back(8'h5A);
        push_acc(1'b1, 32'h8, 4'b0000, 32'h0, '0);
        rx_pulse();
        wait_done(100);
        chk("rx_byte2", {24'b0, rx_data}, 32'h3C);
        status = 8'h0;
        rx_q.push_back(8'h3C);
        rx_pulse();
        wait_done(20);
        chk("rx_empty", {31'b0, rx_valid}, 0);

        // Stalled write: 3 wait cycles
        stall_mode = 1'b1;
        add_byte(2, 8'h99, 1'b1);
        push_wr(2, 8'h99);
        status = 8'h1;
        wait_done(100);
        status = 8'h0;
        stall_mode = 1'b0;

        // Packet from req0 while req1 waits (rr_ptr is 3 here)
        add_byte(0, 8'h10, 1'b0);
        add_byte(0, 8'h11, 1'b0);
        add_byte(0, 8'h12, 1'b1);
        add_byte(1, 8'h20, 1'b1);
`ifdef UART_BUS_SCHED_PKT_LOCK_EN
        push_wr(0, 8'h10);
        push_wr(0, 8'h11);
        push_wr(0, 8'h12);
        push_wr(1, 8'h20);
`else
        push_wr(0, 8'h10);
        push_wr(1, 8'h20);
        push_wr(0, 8'h11);
        push_wr(0, 8'h12);
`endif
        status = 8'h1;
        wait_done(200);
        status = 8'h0;

        // Reset mid-access drops sel at once and INIT repeats
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_sel", {31'b0, sel_out}, 0);
        chk("rst_mid_busy", {31'b0, busy}, 0);
        push_acc(1'b0, 32'h0, 4'b0011, 32'h0000_0067, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        wait_done(50);
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_bus_sched.md
Name: uart_bus_sched

Overview:
- Bus master that owns the memory-bus slave port of one UART instance and shares its transmitter between NUM_REQ byte-stream requesters, using round-robin arbitration.
- Programs the UART clock divider after reset.
- Polls the UART status register, drains received bytes into a one-entry holding register, and presents them on a valid/ready stream.
- Sits between the UART peripheral and on-chip agents (debug console, boot loader, logger) so that no CPU software is needed for the console path.

Parameters:
- NUM_REQ, 4, number of TX requesters (1..8).
- BASE_ADDR, 32'h0000_0000, UART base address on the bus; register offsets: CLK_DIV +0x0, STATUS +0x4, DATA +0x8.
- CLK_DIV_INIT, 16'd103, divider value written once after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has a byte
- req_data  in  8*NUM_REQ  byte for requester i, at bits [8i+7:8i]
- req_last  in  NUM_REQ  last byte of a packet (used only with the optional feature)
- req_ready  out  NUM_REQ  one-hot; byte of requester i is consumed this cycle
- rx_valid  out  1  received byte is available
- rx_data  out  8  received byte
- rx_ready  in  1  consumer accepts rx_data
- address_out  out  32  bus address
- sel_out  out  1  bus select
- read_out  out  1  bus read strobe
- write_mask_out  out  4  bus byte-write mask
- write_value_out  out  32  bus write data
- read_value_in  in  32  bus read data
- ready_in  in  1  bus access completes this cycle
- busy  out  1  state is not IDLE_POLL, or a grant is held

Behaviour:
- Reset values (reset=0): all outputs 0, state=INIT, rr_ptr=0, rx holding register empty. Reset takes effect asynchronously; release is sampled on the clk edge.
- Bus access rules:
  - Each access holds sel_out, address, mask, data and read stable until the cycle in which ready_in=1. The access completes in that cycle.
  - Read data is captured from read_value_in in the completing cycle.
  - sel_out=0 in any cycle without an access.
- States:
  - INIT: write CLK_DIV_INIT to +0x0 with mask 4'b0011. Goes to POLL on completion.
  - POLL: read +0x4 and capture tx_rdy=bit0, rx_rdy=bit1. On completion, decide in this order:
    - rx_rdy=1 and holding register empty -> RD.
    - Otherwise, tx_rdy=1 and any req_valid -> WR.
    - Otherwise -> POLL.
  - RD: read +0x8, store bits[7:0] into the holding register, set rx_valid. Goes to POLL.
  - WR: write {24'b0, granted byte} to +0x8 with mask 4'b0001. In the completing cycle, req_ready[g]=1 for exactly that one cycle. Goes to POLL.
- RX has priority over TX when both are ready (this minimises overrun).
- Arbitration:
  - The grant g is the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around. It is chosen when entering WR and frozen for that access.
  - After a completed WR, rr_ptr = (g+1) mod NUM_REQ.
- req_valid dropping during WR is a protocol violation by the requester. The byte is still written; no check is required.
- RX stream:
  - rx_valid stays high until rx_valid & rx_ready. The holding register empties on that edge.
  - A new RD may start in the next POLL.
  - While the holding register is full, UART RX bytes are not read; overrun is the UART's behaviour.
- Every WR is followed by a POLL, so a UART busy transmitting is never written twice.
- NUM_REQ=1: arbitration degenerates; rr_ptr stays 0.
- Reset asserted mid-access drops sel_out immediately. After release, INIT is repeated.

Optional Feature:
- Macro: UART_BUS_SCHED_PKT_LOCK_EN.
- Defined:
  - After a WR for requester g with req_last[g]=0, the grant locks to g.
  - Subsequent WRs serve only g; other requesters wait even if valid.
  - The lock releases after a WR with req_last[g]=1. rr_ptr advances only on release.
  - busy=1 while locked.
- Undefined: req_last is ignored; arbitration is per byte.

Test Plan:
- Reset release, ready_in tied 1 -> first access is a write to 0x0 of 0x0067 with mask 0011, then a read of 0x4.
- Status 0x1, req_valid=4'b1010, data1=0x41, data3=0x42 -> writes 0x41 then 0x42 to 0x8, each followed by a POLL; req_ready pulses 0010 then 1000.
- Status 0x3 with req_valid=0001 -> RD precedes WR; rx_data=read byte 0x5A, then the TX write occurs.
- rx_ready=0 with the holding register full and status 0x2 -> no further reads of 0x8; asserting rx_ready resumes reading.
- ready_in low for 3 cycles during a WR -> bus signals stable for 4 cycles; req_ready pulses only in the 4th.
- PKT_LOCK_EN defined, req0 sends 3 bytes (last on the 3rd) while req1 is valid -> req1 is served only after the 3rd byte of req0.
